spi_master_core: RTL and testbench

- Single-lane SPI master engine (mode 0: CPOL=0, CPHA=0, MSB first).
- Sits directly upstream of the SPI tristate/IOBUF manager.
- Drives that manager's MOSI, SCK and per-slave select inputs and their tristate controls, and samples MISO returned from it.
- Accepts one transfer command per valid/ready handshake and returns received data with a one-cycle response pulse.

---
 rtl/spi_master_core.sv | 160 ++++++++++++++++
 tb/tb_spi_master_core.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_core.sv
// Mode-0 SPI master (CPOL=0, CPHA=0, MSB first), one transfer per cmd handshake, rsp is a one-cycle pulse.
// Latency handshake -> cmd_ready is CLK_DIV*(2n+2)+1 cycles; cmd_ready stays low while busy, rsp cannot be stalled.
module spi_master_core #(
  parameter int NBR_OF_SLAVE = 3,
  parameter int DATA_WIDTH   = 32,
  parameter int CLK_DIV      = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [$clog2(NBR_OF_SLAVE)-1:0] cmd_sel,
  input  logic [$clog2(DATA_WIDTH+1)-1:0] cmd_nbits,
  input  logic [DATA_WIDTH-1:0]           cmd_tx,
  output logic                            rsp_valid,
  output logic                            rsp_err,
  output logic [DATA_WIDTH-1:0]           rsp_rx,
  output logic                            mosi_o,
  output logic                            mosi_t,
  input  logic                            miso_i,
  output logic                            miso_t,
  output logic                            sck_o,
  output logic                            sck_t,
  output logic [NBR_OF_SLAVE-1:0]         ss_o,
  output logic                            ss_t
);

  localparam int SW = $clog2(NBR_OF_SLAVE);
  localparam int NW = $clog2(DATA_WIDTH + 1);
  localparam int IW = $clog2(DATA_WIDTH);
  localparam int DW = $clog2(CLK_DIV);

  // One-hot so that sck_o and the select decode come straight off flops.
  typedef enum logic [5:0] {
    S_IDLE  = 6'b000001,
    S_SETUP = 6'b000010,
    S_HIGH  = 6'b000100,
    S_LOW   = 6'b001000,
    S_GAP   = 6'b010000,
    S_ERR   = 6'b100000
  } state_t;

  state_t state, state_nxt;

  logic [SW-1:0]           sel_q;
  logic [NW-1:0]           bits_left;
  logic [DATA_WIDTH-1:0]   tx_q;
  logic [DATA_WIDTH-1:0]   rx_q;
  logic [DW-1:0]           div_cnt;
  logic                    mosi_q;
  logic                    sck_q;
  logic [NBR_OF_SLAVE-1:0] ss_q;
  logic                    rsp_valid_q;
  logic                    rsp_err_q;
  logic [DATA_WIDTH-1:0]   rsp_rx_q;
  logic                    tri_q;

  logic [NW-1:0]           n_eff;
  logic                    sel_bad;
  logic                    div_done;
  logic                    accept;
  logic [IW-1:0]           first_idx;
  logic [IW-1:0]           next_idx;
  logic [SW-1:0]           sel_use;
  logic [NBR_OF_SLAVE-1:0] ss_d;
  logic                    sck_d;
  logic                    rsp_done_d;
  logic                    rsp_err_d;
  logic                    enter_high;
  logic                    mosi_adv;

  assign n_eff     = (cmd_nbits == '0 || cmd_nbits > NW'(DATA_WIDTH)) ? NW'(DATA_WIDTH) : cmd_nbits;
  assign sel_bad   = int'(cmd_sel) >= NBR_OF_SLAVE;
  assign div_done  = (div_cnt == DW'(CLK_DIV - 1));
  assign accept    = cmd_valid && cmd_ready;
  assign first_idx = IW'(n_eff - NW'(1));
  assign next_idx  = IW'(bits_left - NW'(1));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (cmd_valid) state_nxt = sel_bad ? S_ERR : S_SETUP;
      S_ERR:   state_nxt = S_IDLE;
      S_SETUP: if (div_done) state_nxt = S_HIGH;
      S_HIGH:  if (div_done) state_nxt = S_LOW;
      S_LOW:   if (div_done) state_nxt = (bits_left != '0) ? S_HIGH : S_GAP;
      S_GAP:   if (div_done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bus outputs are decoded from the next state and registered, so pins never glitch.
  always_comb begin
    cmd_ready  = (state == S_IDLE) && !rst;
    sel_use    = (state == S_IDLE) ? cmd_sel : sel_q;
    ss_d       = '1;
    if (state_nxt inside {S_SETUP, S_HIGH, S_LOW}) begin
      for (int i = 0; i < NBR_OF_SLAVE; i++) ss_d[i] = (int'(sel_use) != i);
    end
    sck_d      = (state_nxt == S_HIGH);
    rsp_done_d = (state == S_LOW) && (state_nxt == S_GAP);
    rsp_err_d  = (state_nxt == S_ERR);
    enter_high = (state_nxt == S_HIGH) && (state != S_HIGH);
    mosi_adv   = (state == S_HIGH) && (state_nxt == S_LOW) && (bits_left != '0);
  end

  always_ff @(posedge clk) begin
    tri_q <= rst;
    if (rst) begin
      sel_q       <= '0;
      bits_left   <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      div_cnt     <= '0;
      mosi_q      <= 1'b0;
      sck_q       <= 1'b0;
      ss_q        <= '1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rx_q    <= '0;
    end else begin
      div_cnt <= (state_nxt != state) ? '0 : div_cnt + DW'(1);
      if (accept) begin
        sel_q     <= cmd_sel;
        bits_left <= n_eff;
        tx_q      <= cmd_tx;
        rx_q      <= '0;
        if (!sel_bad) mosi_q <= cmd_tx[first_idx];
      end
      if (enter_high) begin
        rx_q      <= {rx_q[DATA_WIDTH-2:0], miso_i};
        bits_left <= bits_left - NW'(1);
      end
      if (mosi_adv) mosi_q <= tx_q[next_idx];
      sck_q       <= sck_d;
      ss_q        <= ss_d;
      rsp_valid_q <= rsp_done_d || rsp_err_d;
      rsp_err_q   <= rsp_err_d;
      if (rsp_err_d)       rsp_rx_q <= '0;
      else if (rsp_done_d) rsp_rx_q <= rx_q;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rx    = rsp_rx_q;
  assign mosi_o    = mosi_q;
  assign sck_o     = sck_q;
  assign ss_o      = ss_q;
  assign mosi_t    = tri_q;
  assign sck_t     = tri_q;
  assign ss_t      = tri_q;
  assign miso_t    = 1'b1;

endmodule

// File: tb/tb_spi_master_core.sv
// Scoreboard bench for spi_master_core: a driver queues expected responses/frames, monitors pop and compare.
`timescale 1ns/1ps
module tb_spi_master_core;

  localparam int CLK_DIV = 4;
  localparam int BUDGET  = 2000;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_sel;
  logic [5:0]  cmd_nbits;
  logic [31:0] cmd_tx;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rx;
  logic        mosi_o, mosi_t, miso_i, miso_t, sck_o, sck_t, ss_t;
  logic [2:0]  ss_o;

  int miso_mode = 0;  // 0 loopback, 1 tied high, 2 tied low
  assign miso_i = (miso_mode == 0) ? mosi_o : (miso_mode == 1);

  always #5 clk = ~clk;

  spi_master_core #(.NBR_OF_SLAVE(3), .DATA_WIDTH(32), .CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_sel(cmd_sel), .cmd_nbits(cmd_nbits), .cmd_tx(cmd_tx),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rx(rsp_rx),
    .mosi_o(mosi_o), .mosi_t(mosi_t), .miso_i(miso_i), .miso_t(miso_t),
    .sck_o(sck_o), .sck_t(sck_t), .ss_o(ss_o), .ss_t(ss_t)
  );

  typedef struct { logic err; logic [31:0] rx; } rsp_t;
  typedef struct { int sel; int n; logic [63:0] bits; } frm_t;
  rsp_t rsp_q[$];
  frm_t frm_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rx(input int neff, input logic [31:0] tx);
    logic [63:0] mask;
    mask = (64'd1 << neff) - 64'd1;
    case (miso_mode)
      0:       return tx & mask[31:0];
      1:       return mask[31:0];
      default: return 32'd0;
    endcase
  endfunction

  // Response monitor
  always @(negedge clk) begin : mon_rsp
    rsp_t r;
    if (!rst && rsp_valid) begin
      check("rsp_expected", rsp_q.size() > 0, 1);
      if (rsp_q.size() > 0) begin
        r = rsp_q.pop_front();
        check("rsp_err", rsp_err, r.err);
        check("rsp_rx", rsp_rx, r.rx);
      end
    end
  end

  // Bus monitor: one frame = one contiguous stretch with a select low
  bit          in_frame = 0;
  logic [2:0]  frame_ss;
  int          pulses, run, idle_run = 0, last_gap = 0;
  logic        prev_sck;
  logic [63:0] mosi_acc;

  always @(negedge clk) begin : mon_bus
    frm_t       f;
    logic [2:0] e;
    if (rst) begin
      in_frame = 0;
      idle_run = 0;
    end else begin
      check("one_select_max", $countones(~ss_o) <= 1, 1);
      if (!in_frame) begin
        check("sck_idle", sck_o, 1'b0);
        if (ss_o != 3'b111) begin
          in_frame = 1; frame_ss = ss_o; pulses = 0; mosi_acc = '0;
          prev_sck = 1'b0; run = 1; last_gap = idle_run;
        end else idle_run++;
      end else if (ss_o == 3'b111) begin
        check("frame_expected", frm_q.size() > 0, 1);
        if (frm_q.size() > 0) begin
          f = frm_q.pop_front();
          e = 3'b111;
          e[f.sel] = 1'b0;
          check("frame_ss", frame_ss, e);
          check("frame_pulses", pulses, f.n);
          check("frame_mosi", mosi_acc, f.bits);
        end
        in_frame = 0;
        idle_run = 1;
      end else begin
        check("ss_stable", ss_o, frame_ss);
        if (sck_o != prev_sck) begin
          check(sck_o ? "sck_low_len" : "sck_high_len", run, CLK_DIV);
          run = 1;
          if (sck_o) begin
            pulses++;
            mosi_acc = {mosi_acc[62:0], mosi_o};
          end
        end else run++;
        prev_sck = sck_o;
      end
    end
  end

  task automatic send(input int sel, input int nb, input logic [31:0] tx, input bit hold);
    int neff, c, rsp_at, exp_ready, exp_rsp;
    bit got, bad;
    logic [63:0] mask;
    rsp_t r;
    frm_t f;
    neff = (nb == 0 || nb > 32) ? 32 : nb;
    mask = (64'd1 << neff) - 64'd1;
    bad  = (sel >= 3);
    cmd_sel = sel[1:0]; cmd_nbits = nb[5:0]; cmd_tx = tx; cmd_valid = 1'b1;
    got = 0;
    for (int i = 0; i < BUDGET; i++) begin
      if (cmd_ready) begin got = 1; break; end
      @(posedge clk); #1;
    end
    check("accept_in_time", got, 1);
    r.err = bad;
    r.rx  = bad ? 32'd0 : exp_rx(neff, tx);
    rsp_q.push_back(r);
    if (!bad) begin
      f.sel = sel; f.n = neff; f.bits = {32'd0, tx} & mask;
      frm_q.push_back(f);
    end
    @(posedge clk); #1;
    if (!hold) cmd_valid = 1'b0;
    rsp_at = -1; got = 0;
    for (c = 1; c < BUDGET; c++) begin
      if (rsp_valid && rsp_at < 0) rsp_at = c;
      if (cmd_ready) begin got = 1; break; end
      @(posedge clk); #1;
    end
    exp_ready = bad ? 2 : CLK_DIV * (2 * neff + 2) + 1;
    exp_rsp   = bad ? 1 : CLK_DIV * (2 * neff + 1) + 1;
    check("ready_latency", got ? c : -1, exp_ready);
    check("rsp_cycle", rsp_at, exp_rsp);
    check("rsp_rx_held", rsp_rx, r.rx);
  endtask

  initial begin
    int rises;
    logic prev;
    bit got;
    rst = 1'b1; cmd_valid = 1'b0; cmd_sel = '0; cmd_nbits = '0; cmd_tx = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", cmd_ready, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_rsp_rx", rsp_rx, 32'd0);
    check("rst_sck", sck_o, 1'b0);
    check("rst_mosi", mosi_o, 1'b0);
    check("rst_ss", ss_o, 3'b111);
    check("rst_tri", {mosi_t, sck_t, ss_t, miso_t}, 4'b1111);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready", cmd_ready, 1'b1);
    check("post_rst_tri", {mosi_t, sck_t, ss_t, miso_t}, 4'b0001);

    miso_mode = 0; send(1, 8, 32'hA5, 0);
    miso_mode = 1; send(0, 0, $urandom, 0);
    miso_mode = 2; send(2, 40, $urandom, 0);
    miso_mode = 0; send(3, 8, 32'hFF, 0);

    // Back-to-back with cmd_valid held high
    send(2, 5, 32'h15, 1);
    send(0, 3, 32'h6, 0);
    check("b2b_gap", last_gap, CLK_DIV + 1);

    // Reset during the third HIGH phase
    cmd_sel = 2'd2; cmd_nbits = 6'd8; cmd_tx = $urandom; cmd_valid = 1'b1;
    got = 0;
    for (int i = 0; i < BUDGET; i++) begin
      if (cmd_ready) begin got = 1; break; end
      @(posedge clk); #1;
    end
    check("abort_accept", got, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rises = 0; prev = sck_o;
    for (int i = 0; i < BUDGET && rises < 3; i++) begin
      @(posedge clk); #1;
      if (sck_o && !prev) rises++;
      prev = sck_o;
    end
    check("abort_reached_high3", rises, 3);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_ss", ss_o, 3'b111);
    check("abort_sck", sck_o, 1'b0);
    check("abort_tri", {mosi_t, sck_t, ss_t, miso_t}, 4'b1111);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_ready", cmd_ready, 1'b1);
    send(0, 4, 32'h9, 0);

    for (int k = 0; k < 30; k++) begin
      miso_mode = $urandom_range(0, 2);
      send($urandom_range(0, 3), $urandom_range(0, 40), $urandom, 0);
    end

    repeat (3) @(posedge clk);
    #1;
    check("rsp_queue_drained", rsp_q.size(), 0);
    check("frame_queue_drained", frm_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
